// File: rtl/ofdm_cp_inserter.sv
// OFDM cyclic-prefix inserter: ping-pong buffers N-sample symbols and emits
// each one as its last L samples (the CP) followed by all N body samples.
// Optional build macro CP_INSERT_LEAD_ZERO_EN adds a lead_zero port and a PAD
// state that emits lead_zero zero-valued samples once after reset.
module ofdm_cp_inserter #(
  parameter int unsigned N      = 256,
  parameter int unsigned L      = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CP_INSERT_LEAD_ZERO_EN
  input  logic [15:0]       lead_zero,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_sof,
  output logic              out_cp,
  output logic [15:0]       sym_cnt
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned SMP_W = 2 * DATA_W;
  localparam logic [IDX_W-1:0] CP_START = IDX_W'(N - L);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

`ifdef CP_INSERT_LEAD_ZERO_EN
  typedef enum logic [1:0] {S_IDLE, S_CP, S_BODY, S_PAD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_CP, S_BODY} state_t;
`endif

  logic [SMP_W-1:0] r_mem [0:2*N-1];
  logic             r_wr_bank;
  logic [IDX_W-1:0] r_wr_idx;
  logic [1:0]       r_full;
  logic             r_rd_bank;
  logic [IDX_W-1:0] r_rd_idx;
  logic             r_out_last;
  state_t           r_state;

  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_rd_idx_nxt;
  logic             w_rd_bank_nxt;
  logic             w_in_fire;
  logic             w_adv;
  logic             w_issue;
  logic [IDX_W-1:0] w_issue_idx;
  logic             w_issue_sof;
  logic             w_issue_cp;
  logic             w_issue_last;
  logic [1:0]       w_full_set;
  logic [1:0]       w_full_clr;
  logic             w_other_bank;
  logic [SMP_W-1:0] w_rd_data;
  logic [SMP_W-1:0] w_out_data;

  assign in_ready     = !r_full[r_wr_bank] && !rst;
  assign w_in_fire    = in_valid && in_ready;
  assign w_adv        = !out_valid || out_ready;
  assign w_other_bank = ~r_rd_bank;
  assign w_rd_data    = r_mem[{r_rd_bank, w_issue_idx}];

`ifdef CP_INSERT_LEAD_ZERO_EN
  logic        r_pad_arm;
  logic [15:0] r_pad_cnt;
  logic        w_issue_zero;

  assign w_out_data = w_issue_zero ? '0 : w_rd_data;

  // Capture the pad length on the first cycle out of reset, then count it down
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pad_arm <= 1'b1;
      r_pad_cnt <= 16'd0;
    end else if (r_pad_arm) begin
      r_pad_arm <= 1'b0;
      r_pad_cnt <= lead_zero;
    end else if (w_issue_zero) begin
      r_pad_cnt <= r_pad_cnt - 16'd1;
    end
  end
`else
  assign w_out_data = w_rd_data;
`endif

  assign w_full_set = (w_in_fire && r_wr_idx == LAST_IDX) ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;

  // Sample storage; no reset, validity is tracked by the full flags
  always_ff @(posedge clk) begin
    if (w_in_fire) r_mem[{r_wr_bank, r_wr_idx}] <= {in_re, in_im};
  end

  // Write pointer and bank full flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_wr_idx  <= '0;
      r_full    <= 2'b00;
    end else begin
      if (w_in_fire) begin
        r_wr_idx <= r_wr_idx + IDX_W'(1);
        if (r_wr_idx == LAST_IDX) r_wr_bank <= ~r_wr_bank;
      end
      r_full <= (r_full | w_full_set) & ~w_full_clr;
    end
  end

  // Read FSM: pick the next sample to load into the output register
  always_comb begin
    w_state_nxt   = r_state;
    w_rd_idx_nxt  = r_rd_idx;
    w_rd_bank_nxt = r_rd_bank;
    w_issue       = 1'b0;
    w_issue_idx   = r_rd_idx;
    w_issue_sof   = 1'b0;
    w_issue_cp    = 1'b0;
    w_issue_last  = 1'b0;
    w_full_clr    = 2'b00;
`ifdef CP_INSERT_LEAD_ZERO_EN
    w_issue_zero  = 1'b0;
`endif
    case (r_state)
      S_IDLE, S_CP: begin
        // IDLE launches the first CP sample directly to keep latency at two cycles
        if (w_adv && (r_state == S_CP || r_full[r_rd_bank])) begin
          w_issue     = 1'b1;
          w_issue_idx = (r_state == S_IDLE) ? CP_START : r_rd_idx;
          w_issue_cp  = 1'b1;
          w_issue_sof = (w_issue_idx == CP_START);
          if (w_issue_idx == LAST_IDX) begin
            w_state_nxt  = S_BODY;
            w_rd_idx_nxt = '0;
          end else begin
            w_state_nxt  = S_CP;
            w_rd_idx_nxt = w_issue_idx + IDX_W'(1);
          end
        end
      end
      S_BODY: begin
        if (w_adv) begin
          w_issue = 1'b1;
          if (r_rd_idx == LAST_IDX) begin
            // Last body sample is now in the output register, so the bank is free
            w_issue_last          = 1'b1;
            w_full_clr[r_rd_bank] = 1'b1;
            w_rd_bank_nxt         = w_other_bank;
            if (r_full[w_other_bank]) begin
              w_state_nxt  = S_CP;
              w_rd_idx_nxt = CP_START;
            end else begin
              w_state_nxt  = S_IDLE;
              w_rd_idx_nxt = '0;
            end
          end else begin
            w_rd_idx_nxt = r_rd_idx + IDX_W'(1);
          end
        end
      end
`ifdef CP_INSERT_LEAD_ZERO_EN
      S_PAD: begin
        if (!r_pad_arm) begin
          if (r_pad_cnt == 16'd0) begin
            w_state_nxt = S_IDLE;
          end else if (w_adv) begin
            w_issue      = 1'b1;
            w_issue_zero = 1'b1;
          end
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef CP_INSERT_LEAD_ZERO_EN
      r_state <= S_PAD;
`else
      r_state <= S_IDLE;
`endif
      r_rd_idx  <= '0;
      r_rd_bank <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_idx  <= w_rd_idx_nxt;
      r_rd_bank <= w_rd_bank_nxt;
    end
  end

  // Output register doubles as the registered memory read; holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_cp     <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
      r_out_last <= 1'b0;
      sym_cnt    <= 16'd0;
    end else begin
      if (w_adv) begin
        out_valid  <= w_issue;
        out_sof    <= w_issue_sof;
        out_cp     <= w_issue_cp;
        r_out_last <= w_issue_last;
        if (w_issue) {out_re, out_im} <= w_out_data;
      end
      if (out_valid && out_ready && r_out_last) sym_cnt <= sym_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Self-checking bench for ofdm_cp_inserter: a queue-based model turns every
// completed input symbol into its expected CP+body output sequence.
module tb_ofdm_cp_inserter;

  localparam int N = 256;
  localparam int L = 16;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic        sof;
    logic        cp;
  } smp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_re;
  logic [15:0] in_im;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_re;
  logic [15:0] out_im;
  logic        out_sof;
  logic        out_cp;
  logic [15:0] sym_cnt;

  ofdm_cp_inserter dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_sof(out_sof), .out_cp(out_cp), .sym_cnt(sym_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [31:0] in_q[$];
  logic [31:0] sym_buf[$];
  smp_t        exp_q[$];

  int   last_full_cyc;
  int   first_out_cyc;
  int   gaps;
  int   n_acc;
  int   drop_at;
  int   n_out;
  logic [31:0] first_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // A completed symbol becomes its last L samples (CP) followed by all N
  task automatic model_symbol();
    smp_t s;
    for (int i = N - L; i < N; i++) begin
      s.re = sym_buf[i][31:16]; s.im = sym_buf[i][15:0];
      s.sof = (i == N - L); s.cp = 1'b1;
      exp_q.push_back(s);
    end
    for (int i = 0; i < N; i++) begin
      s.re = sym_buf[i][31:16]; s.im = sym_buf[i][15:0];
      s.sof = 1'b0; s.cp = 1'b0;
      exp_q.push_back(s);
    end
    sym_buf.delete();
  endtask

  task automatic push_ramp(input int base);
    for (int k = 0; k < N; k++) in_q.push_back({16'(base + k), 16'(-(base + k))});
  endtask

  task automatic push_rand(input int nsym);
    for (int k = 0; k < nsym * N; k++) in_q.push_back($urandom);
  endtask

  // rdy_mode 0: out_ready held high; 1: toggling with random 3-cycle stalls
  task automatic run(input int gap_pct, input int rdy_mode, input int max_cyc);
    logic        stalled = 1'b0;
    logic [33:0] held = '0;
    int          stall_left = 0;
    logic        tog = 1'b0;
    bit          done = 0;
    smp_t        e;
    last_full_cyc = -1; first_out_cyc = -1; gaps = 0; n_acc = 0; drop_at = -1; n_out = 0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge clk);
      if (stalled) chk("stall_hold", {out_valid, out_re, out_im, out_sof, out_cp}, {1'b1, held});
      if (in_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
        in_valid = 1'b1; {in_re, in_im} = in_q[0];
      end else begin
        in_valid = 1'b0;
      end
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
      else if ($urandom_range(9) == 0) begin out_ready = 1'b0; stall_left = 2; end
      else begin tog = ~tog; out_ready = tog; end
      if (in_valid && !in_ready && drop_at < 0) drop_at = n_acc;
      if (in_valid && in_ready) begin
        sym_buf.push_back(in_q.pop_front());
        n_acc++;
        if (sym_buf.size() == N) begin model_symbol(); last_full_cyc = cyc; end
      end
      if (out_valid && first_out_cyc < 0) begin first_out_cyc = cyc; first_out = {out_re, out_im}; end
      if (first_out_cyc >= 0 && !out_valid && exp_q.size() > 0) gaps++;
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) chk("extra_output", {out_re, out_im}, 64'hDEAD);
        else begin
          e = exp_q.pop_front();
          chk("out_sample", {out_re, out_im, out_sof, out_cp}, e);
        end
      end
      stalled = out_valid && !out_ready;
      held = {out_re, out_im, out_sof, out_cp};
      if (in_q.size() == 0 && exp_q.size() == 0 && sym_buf.size() % N == 0 &&
          !(out_valid && !out_ready)) done = 1;
      @(posedge clk);
    end
    if (!done) chk("timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1 chk("in_ready_in_rst", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sof_cp", {out_sof, out_cp, out_re, out_im}, 64'd0);
    chk("rst_sym_cnt", 64'(sym_cnt), 64'd0);
    rst = 1'b0;
    #1 chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    sym_buf.delete();
    exp_q.delete();
  endtask

  int vcount;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_re = '0; in_im = '0;
    do_reset();

    // Single ramp symbol: latency, CP order and symbol count
    push_ramp(0);
    run(0, 0, 2000);
    chk("t1_latency", 64'(first_out_cyc - last_full_cyc), 64'd2);
    chk("t1_first_out", 64'(first_out), {16'd240, 16'(-240)});
    chk("t1_n_out", 64'(n_out), 64'd272);
    chk("t1_sym_cnt", 64'(sym_cnt), 64'd1);

    // Four back-to-back random symbols: no output gaps, backpressure at 512
    push_rand(4);
    run(0, 0, 4000);
    chk("t2_n_out", 64'(n_out), 64'd1088);
    chk("t2_gaps", 64'(gaps), 64'd0);
    chk("t2_in_ready_drop", 64'(drop_at), 64'd512);
    chk("t2_sym_cnt", 64'(sym_cnt), 64'd5);

    // Toggling out_ready with random stalls
    push_rand(2);
    run(0, 1, 8000);
    chk("t3_n_out", 64'(n_out), 64'd544);
    chk("t3_sym_cnt", 64'(sym_cnt), 64'd7);
    vcount = 0;
    repeat (10) begin @(negedge clk); if (out_valid) vcount++; end
    chk("t3_no_trailing", 64'(vcount), 64'd0);

    // Partial symbol then reset: discarded data must never appear
    for (int k = 0; k < 100; k++) in_q.push_back({16'(k + 16'h0500), 16'(k)});
    run(0, 0, 500);
    chk("t4_partial_no_out", 64'(n_out), 64'd0);
    do_reset();
    vcount = 0;
    repeat (20) begin @(negedge clk); if (out_valid) vcount++; end
    chk("t4_idle_after_rst", 64'(vcount), 64'd0);
    push_ramp(16'h1000);
    run(0, 0, 2000);
    chk("t4_first_out", 64'(first_out), {16'h1000 + 16'd240, 16'(-(16'h1000 + 240))});
    chk("t4_sym_cnt", 64'(sym_cnt), 64'd1);

    // Random input gaps plus random output stalls: content unchanged
    push_rand(2);
    run(35, 0, 6000);
    chk("t5_n_out", 64'(n_out), 64'd544);
    push_rand(1);
    run(35, 1, 6000);
    chk("t5_sym_cnt", 64'(sym_cnt), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
